// File: rtl/garegga_video_timing_if.sv
// Signal bundle between the raster timing generator and its consumers:
// pixel enable, sync offsets and interrupt ack in; counters, blanking, sync, VINT and frame out.
interface garegga_video_timing_if;
  logic       CEN675;
  logic [3:0] HOFFSET;
  logic [3:0] VOFFSET;
  logic       INT_ACK;
  logic [8:0] HCNT;
  logic [8:0] VCNT;
  logic       HBLANK;
  logic       VBLANK;
  logic       HSYNC;
  logic       VSYNC;
  logic       VINT_N;
  logic       FRAME;

  modport master (
    input  CEN675, HOFFSET, VOFFSET, INT_ACK,
    output HCNT, VCNT, HBLANK, VBLANK, HSYNC, VSYNC, VINT_N, FRAME
  );

  modport slave (
    output CEN675, HOFFSET, VOFFSET, INT_ACK,
    input  HCNT, VCNT, HBLANK, VBLANK, HSYNC, VSYNC, VINT_N, FRAME
  );
endinterface

// File: rtl/garegga_video_timing.sv
// Raster timing generator: H/V counters on the pixel enable, registered blanking and
// offset-adjustable sync coherent with the counters, vertical interrupt and frame toggle.
module garegga_video_timing #(
  parameter int HTOTAL   = 432,
  parameter int HACTIVE  = 320,
  parameter int HS_START = 352,
  parameter int HS_W     = 32,
  parameter int VTOTAL   = 262,
  parameter int VACTIVE  = 240,
  parameter int VS_START = 244,
  parameter int VS_W     = 3
) (
  input  logic                   CLK96,
  input  logic                   RESET_N,
  garegga_video_timing_if.master vt
);

  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(HACTIVE);
  localparam logic [8:0] V_ACT  = 9'(VACTIVE);

  typedef enum logic {IDLE, PEND} vint_state_t;

  // Nominal start shifted by a signed offset, folded back into 0..total-1.
  function automatic logic signed [10:0] sync_start(input int start,
                                                    input logic signed [3:0] offset,
                                                    input int total);
    logic signed [10:0] s;
    s = 11'(start) + 11'(offset);
    if (s < 11'sd0)
      s = s + 11'(total);
    else if (s >= 11'(total))
      s = s - 11'(total);
    return s;
  endfunction

  // True when cnt lies within width positions after first, wrapping past total-1.
  function automatic logic in_sync(input logic [8:0] cnt,
                                   input logic signed [10:0] first,
                                   input int width,
                                   input int total);
    logic signed [11:0] d;
    d = $signed({3'b000, cnt}) - 12'(first);
    if (d < 12'sd0)
      d = d + 12'(total);
    return d < 12'(width);
  endfunction

  logic        [8:0]  hcnt_p0, vcnt_p0;
  logic        [8:0]  hcnt_p1, vcnt_p1;
  logic               hblank_p1, vblank_p1, hsync_p1, vsync_p1, frame_p1;
  logic signed [3:0]  hoff_lat, voff_lat, hoff_sel, voff_sel;
  logic signed [10:0] hs_eff, vs_eff;
  logic               h_wrap, frame_start, vint_set;
  vint_state_t        state, state_nxt;

  // Stage p0: next counter values and the sync window they fall into.
  always_comb begin
    h_wrap      = (hcnt_p1 == H_LAST);
    frame_start = h_wrap && (vcnt_p1 == V_LAST);
    hcnt_p0     = h_wrap ? 9'd0 : hcnt_p1 + 9'd1;
    vcnt_p0     = frame_start ? 9'd0 : (h_wrap ? vcnt_p1 + 9'd1 : vcnt_p1);
    // The first pixel of a new frame already uses the offsets captured for that frame.
    hoff_sel    = frame_start ? $signed(vt.HOFFSET) : hoff_lat;
    voff_sel    = frame_start ? $signed(vt.VOFFSET) : voff_lat;
    hs_eff      = sync_start(HS_START, hoff_sel, HTOTAL);
    vs_eff      = sync_start(VS_START, voff_sel, VTOTAL);
    vint_set    = vt.CEN675 && h_wrap && (vcnt_p0 == V_ACT);
  end

  // Stage p1: registered counters and raster flags.
  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_p1   <= '0;
      vcnt_p1   <= '0;
      hblank_p1 <= 1'b0;
      vblank_p1 <= 1'b0;
      hsync_p1  <= 1'b0;
      vsync_p1  <= 1'b0;
      frame_p1  <= 1'b0;
      hoff_lat  <= '0;
      voff_lat  <= '0;
    end else if (vt.CEN675) begin
      hcnt_p1   <= hcnt_p0;
      vcnt_p1   <= vcnt_p0;
      hblank_p1 <= (hcnt_p0 >= H_ACT);
      vblank_p1 <= (vcnt_p0 >= V_ACT);
      hsync_p1  <= in_sync(hcnt_p0, hs_eff, HS_W, HTOTAL);
      vsync_p1  <= in_sync(vcnt_p0, vs_eff, VS_W, VTOTAL);
      if (frame_start) begin
        frame_p1 <= ~frame_p1;
        hoff_lat <= hoff_sel;
        voff_lat <= voff_sel;
      end
    end
  end

  always_ff @(posedge CLK96 or negedge RESET_N) begin
    if (!RESET_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // A set on the same cycle as an ack keeps the request pending.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (vint_set) state_nxt = PEND;
      PEND:    if (!vint_set && vt.INT_ACK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign vt.HCNT   = hcnt_p1;
  assign vt.VCNT   = vcnt_p1;
  assign vt.HBLANK = hblank_p1;
  assign vt.VBLANK = vblank_p1;
  assign vt.HSYNC  = hsync_p1;
  assign vt.VSYNC  = vsync_p1;
  assign vt.VINT_N = (state == IDLE);
  assign vt.FRAME  = frame_p1;

endmodule

// File: tb/tb_garegga_video_timing.sv
// Bench for garegga_video_timing on a shrunken raster: directed literal checks plus
// randomized enables, acks, offsets and resets compared every cycle against a position model.
module tb_garegga_video_timing;
  localparam int HT  = 40;
  localparam int HA  = 30;
  localparam int HS  = 36;
  localparam int HSW = 4;
  localparam int VT  = 20;
  localparam int VA  = 15;
  localparam int VS  = 16;
  localparam int VSW = 2;
  localparam int FL  = HT * VT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  garegga_video_timing_if vt ();

  garegga_video_timing #(
    .HTOTAL(HT), .HACTIVE(HA), .HS_START(HS), .HS_W(HSW),
    .VTOTAL(VT), .VACTIVE(VA), .VS_START(VS), .VS_W(VSW)
  ) dut (
    .CLK96  (clk),
    .RESET_N(rst_n),
    .vt     (vt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: enables since reset, pending interrupt, offsets in force this frame.
  int n_m    = 0;
  bit pend_m = 1'b0;
  int hoff_m = 0;
  int voff_m = 0;

  int en_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  function automatic int modp(input int a, input int m);
    int r;
    r = a % m;
    if (r < 0) r += m;
    return r;
  endfunction

  function automatic bit in_win(input int pos, input int start, input int off,
                                input int w, input int total);
    return modp(pos - modp(start + off, total), total) < w;
  endfunction

  initial begin : compare
    forever begin
      bit set;
      int h, v;
      @(posedge clk);
      set = 1'b0;
      if (!rst_n) begin
        n_m = 0; pend_m = 1'b0; hoff_m = 0; voff_m = 0;
      end else begin
        if (vt.CEN675) begin
          n_m++;
          if (n_m % FL == 0) begin
            hoff_m = sx4(vt.HOFFSET);
            voff_m = sx4(vt.VOFFSET);
          end
          set = ((n_m % FL) == VA * HT);
        end
        if (set) pend_m = 1'b1;
        else if (vt.INT_ACK) pend_m = 1'b0;
      end
      #1;
      h = n_m % HT;
      v = (n_m / HT) % VT;
      check("hcnt",   vt.HCNT,   h);
      check("vcnt",   vt.VCNT,   v);
      check("hblank", vt.HBLANK, 32'(h >= HA));
      check("vblank", vt.VBLANK, 32'(v >= VA));
      check("hsync",  vt.HSYNC,  32'(in_win(h, HS, hoff_m, HSW, HT)));
      check("vsync",  vt.VSYNC,  32'(in_win(v, VS, voff_m, VSW, VT)));
      check("vint_n", vt.VINT_N, 32'(!pend_m));
      check("frame",  vt.FRAME,  (n_m / FL) % 2);
    end
  end

  task automatic tick(input bit c, input bit a);
    @(negedge clk);
    vt.CEN675  = c;
    vt.INT_ACK = a;
    @(posedge clk);
    #2;
    if (c) en_cnt++;
  endtask

  task automatic goto(input int target);
    while (en_cnt < target) tick(1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hcnt"},   vt.HCNT,   0);
    check({tag, "_vcnt"},   vt.VCNT,   0);
    check({tag, "_hblank"}, vt.HBLANK, 0);
    check({tag, "_vblank"}, vt.VBLANK, 0);
    check({tag, "_hsync"},  vt.HSYNC,  0);
    check({tag, "_vsync"},  vt.VSYNC,  0);
    check({tag, "_vint_n"}, vt.VINT_N, 1);
    check({tag, "_frame"},  vt.FRAME,  0);
  endtask

  initial begin : driver
    vt.CEN675  = 1'b0;
    vt.INT_ACK = 1'b0;
    vt.HOFFSET = 4'd0;
    vt.VOFFSET = 4'd0;
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    tick(1'b1, 1'b0);
    check("first_en_hcnt", vt.HCNT, 1);

    // Horizontal blanking and sync edges, zero offsets.
    goto(29);  check("hblank_29", vt.HBLANK, 0);
    goto(30);  check("hblank_30", vt.HBLANK, 1);
    goto(35);  check("hsync_35",  vt.HSYNC,  0);
    goto(36);  check("hsync_36",  vt.HSYNC,  1);
    goto(39);  check("hsync_39",  vt.HSYNC,  1);
    goto(40);  check("hwrap_hcnt", vt.HCNT, 0);
               check("hwrap_vcnt", vt.VCNT, 1);
               check("hwrap_hsync", vt.HSYNC, 0);
               check("hwrap_hblank", vt.HBLANK, 0);

    // Vertical blanking, interrupt set and vertical sync.
    goto(599); check("vblank_14", vt.VBLANK, 0);
               check("vint_14",   vt.VINT_N, 1);
    goto(600); check("vblank_15", vt.VBLANK, 1);
               check("vint_15",   vt.VINT_N, 0);
               check("vcnt_15",   vt.VCNT,   15);
    goto(640); check("vsync_16",  vt.VSYNC,  1);
    goto(719); check("vsync_17",  vt.VSYNC,  1);
    goto(720); check("vsync_18",  vt.VSYNC,  0);
    goto(799); check("frame_799", vt.FRAME,  0);
    goto(800); check("frame_800", vt.FRAME,  1);
               check("fwrap_vcnt", vt.VCNT,  0);
               check("fwrap_vblank", vt.VBLANK, 0);
               check("vint_held_f1", vt.VINT_N, 0);

    // VOFFSET changed mid-frame only applies from the next frame.
    goto(1000); vt.VOFFSET = 4'b1000;
    goto(1440); check("voff_same_frame", vt.VSYNC, 1);
    goto(1600); check("voff_line0",  vt.VSYNC, 0);
    goto(1919); check("voff_line7",  vt.VSYNC, 0);
    goto(1920); check("voff_line8",  vt.VSYNC, 1);
    goto(2000); check("voff_line10", vt.VSYNC, 0);
    goto(2240); check("voff_line16", vt.VSYNC, 0);
                check("vint_two_frames", vt.VINT_N, 0);

    // Acknowledge, then ack coinciding with set.
    tick(1'b0, 1'b1); check("ack_clears", vt.VINT_N, 1);
    tick(1'b0, 1'b0); check("ack_stays",  vt.VINT_N, 1);
    goto(2999);
    tick(1'b1, 1'b1); check("set_beats_ack", vt.VINT_N, 0);
    tick(1'b0, 1'b1); check("late_ack",      vt.VINT_N, 1);

    // HSYNC window wrapping past the end of the line.
    vt.HOFFSET = 4'd2;
    vt.VOFFSET = 4'd0;
    goto(3237); check("hwin_37", vt.HSYNC, 0);
    goto(3238); check("hwin_38", vt.HSYNC, 1);
    goto(3240); check("hwin_0",  vt.HSYNC, 1);
    goto(3241); check("hwin_1",  vt.HSYNC, 1);
    goto(3242); check("hwin_2",  vt.HSYNC, 0);

    // Asynchronous reset in the middle of an odd frame.
    goto(4678);
    check("pre_rst_frame",  vt.FRAME,  1);
    check("pre_rst_vint",   vt.VINT_N, 0);
    check("pre_rst_hsync",  vt.HSYNC,  1);
    check("pre_rst_vsync",  vt.VSYNC,  1);
    @(negedge clk);
    rst_n = 1'b0;
    vt.CEN675 = 1'b0;
    vt.INT_ACK = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n  = 1'b1;
    en_cnt = 0;
    vt.HOFFSET = 4'd0;
    tick(1'b1, 1'b0);
    check("midrst_first_hcnt", vt.HCNT, 1);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 3999) != 0);
      vt.CEN675  = ($urandom_range(0, 2) != 0);
      vt.INT_ACK = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 299) == 0) begin
        vt.HOFFSET = 4'($urandom);
        vt.VOFFSET = 4'($urandom);
      end
    end

    @(negedge clk);
    rst_n      = 1'b1;
    vt.CEN675  = 1'b0;
    vt.INT_ACK = 1'b0;
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
